// File: rtl/host_direct_cmd_engine_pkg.sv
// host_direct_cmd_engine_pkg: command, response and host AXI types for the HostDirect engine.
package host_direct_cmd_engine_pkg;
    localparam int AXI_AW = 64;
    localparam int AXI_WIDE_DW = 512;
    localparam int AXI_IW = 8;
    localparam int HOST_DIRECT_MAX_BYTES = AXI_WIDE_DW / 8;
    localparam int OFF_W = $clog2(HOST_DIRECT_MAX_BYTES);
    localparam int SIZE_W = OFF_W + 1;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {CMD_HOSTMEM_COPY, CMD_NIC_SEND, CMD_HOST_DIRECT} cmd_type_e;
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP} hdc_state_e;

    typedef struct packed {
        logic                   nic_to_host;
        logic [AXI_AW-1:0]      host_addr;
        logic [SIZE_W-1:0]      imm_data_size;
        logic [AXI_WIDE_DW-1:0] imm_data;
    } host_direct_cmd_t;

    typedef struct packed {
        host_direct_cmd_t host_direct_cmd;
    } cmd_descr_t;

    typedef struct packed {
        logic [7:0] cmd_id;
        cmd_type_e  cmd_type;
        cmd_descr_t descr;
    } pspin_cmd_t;

    typedef struct packed {
        logic [7:0]             cmd_id;
        logic [AXI_WIDE_DW-1:0] imm_data;
    } pspin_cmd_resp_t;

    typedef struct packed {
        logic [AXI_IW-1:0] id;
        logic [AXI_AW-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic              user;
    } ax_chan_t;

    typedef struct packed {
        logic [AXI_WIDE_DW-1:0]           data;
        logic [HOST_DIRECT_MAX_BYTES-1:0] strb;
        logic                             last;
        logic                             user;
    } w_chan_t;

    typedef struct packed {
        logic [AXI_IW-1:0] id;
        logic [1:0]        resp;
    } b_chan_t;

    typedef struct packed {
        logic [AXI_IW-1:0]      id;
        logic [AXI_WIDE_DW-1:0] data;
        logic [1:0]             resp;
        logic                   last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } host_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } host_resp_t;

    // A command must be HostDirect and its bytes must fit inside one beat.
    function automatic logic hdc_legal(input pspin_cmd_t c, input int max_bytes);
        logic [SIZE_W:0] span;
        span = (SIZE_W+1)'(c.descr.host_direct_cmd.host_addr[OFF_W-1:0])
             + (SIZE_W+1)'(c.descr.host_direct_cmd.imm_data_size);
        return c.cmd_type == CMD_HOST_DIRECT && c.descr.host_direct_cmd.imm_data_size != '0
            && span <= (SIZE_W+1)'(max_bytes);
    endfunction
endpackage

// File: rtl/host_direct_cmd_engine_byte_align.sv
// hdc_byte_align: places immediate bytes into a beat and extracts read bytes from one.
module hdc_byte_align
    import host_direct_cmd_engine_pkg::*;
(
    input  logic [OFF_W-1:0]                 off,
    input  logic [SIZE_W-1:0]                size,
    input  logic [AXI_WIDE_DW-1:0]           wr_data,
    input  logic [AXI_WIDE_DW-1:0]           rd_data,
    output logic [HOST_DIRECT_MAX_BYTES-1:0] strb,
    output logic [AXI_WIDE_DW-1:0]           wr_beat,
    output logic [AXI_WIDE_DW-1:0]           rd_bytes
);
    logic [HOST_DIRECT_MAX_BYTES-1:0] byte_mask;
    logic [AXI_WIDE_DW-1:0]           bit_mask;
    logic [OFF_W+2:0]                 bit_off;

    assign byte_mask = size >= SIZE_W'(HOST_DIRECT_MAX_BYTES) ? '1
                     : (HOST_DIRECT_MAX_BYTES'(1) << size) - HOST_DIRECT_MAX_BYTES'(1);
    assign bit_off = {off, 3'b000};
    assign strb = byte_mask << off;
    assign wr_beat = wr_data << bit_off;
    assign rd_bytes = (rd_data >> bit_off) & bit_mask;

    for (genvar b = 0; b < HOST_DIRECT_MAX_BYTES; b++) begin : g_mask
        assign bit_mask[8*b +: 8] = {8{byte_mask[b]}};
    end
endmodule

// File: rtl/host_direct_cmd_engine.sv
// host_direct_cmd_engine: runs HostDirect commands as single-beat AXI writes/reads to host memory
// and returns one response per command.
module host_direct_cmd_engine
    import host_direct_cmd_engine_pkg::*;
#(
    parameter logic [AXI_IW-1:0] AXI_ID = '0,
    parameter int DATA_BYTES = HOST_DIRECT_MAX_BYTES
)(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  pspin_cmd_t      cmd_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output pspin_cmd_resp_t resp_o,
    output logic            err_o,
    output logic            busy_o,
    output host_req_t       host_req_o,
    input  host_resp_t      host_resp_i
);
    hdc_state_e state, next_state;
    logic [7:0] cmd_id;
    logic [AXI_AW-1:0] host_addr;
    logic [SIZE_W-1:0] size;
    logic [AXI_WIDE_DW-1:0] imm_data, resp_imm, wr_beat, rd_bytes;
    logic [HOST_DIRECT_MAX_BYTES-1:0] strb;
    logic resp_err, aw_done, w_done, legal, accept;
    logic aw_valid, w_valid, ar_valid, b_ready, r_ready;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, r_err;
    ax_chan_t ax;
    logic unused_resp;

    hdc_byte_align u_align (
        .off(host_addr[OFF_W-1:0]),
        .size(size),
        .wr_data(imm_data),
        .rd_data(host_resp_i.r.data),
        .strb(strb),
        .wr_beat(wr_beat),
        .rd_bytes(rd_bytes)
    );

    assign legal = hdc_legal(cmd_i, DATA_BYTES);
    assign cmd_ready_o = state == IDLE;
    assign accept = cmd_valid_i & cmd_ready_o;
    assign aw_valid = state == WR_REQ && !aw_done;
    assign w_valid = state == WR_REQ && !w_done;
    assign ar_valid = state == RD_REQ;
    assign b_ready = state == WR_RESP;
    assign r_ready = state == RD_RESP;
    assign aw_hs = aw_valid & host_resp_i.aw_ready;
    assign w_hs = w_valid & host_resp_i.w_ready;
    assign b_hs = b_ready & host_resp_i.b_valid;
    assign ar_hs = ar_valid & host_resp_i.ar_ready;
    assign r_hs = r_ready & host_resp_i.r_valid;
    assign r_err = host_resp_i.r.resp != AXI_RESP_OKAY;
    assign resp_valid_o = state == RESP;
    assign err_o = resp_valid_o & resp_err;
    assign busy_o = state != IDLE;
    assign resp_o.cmd_id = cmd_id;
    assign resp_o.imm_data = resp_imm;
    assign unused_resp = ^{host_resp_i.b.id, host_resp_i.r.id, host_resp_i.r.last};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cmd_valid_i) next_state = !legal ? RESP
                         : cmd_i.descr.host_direct_cmd.nic_to_host ? WR_REQ : RD_REQ;
            WR_REQ:  if ((aw_done | aw_hs) & (w_done | w_hs)) next_state = WR_RESP;
            WR_RESP: if (b_hs) next_state = RESP;
            RD_REQ:  if (ar_hs) next_state = RD_RESP;
            RD_RESP: if (r_hs) next_state = RESP;
            RESP:    if (resp_ready_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The beat is always aligned to a full bus word; strobes select the bytes.
    always_comb begin
        ax = '0;
        ax.id = AXI_ID;
        ax.addr = {host_addr[AXI_AW-1:OFF_W], OFF_W'(0)};
        ax.size = 3'(OFF_W);
        ax.burst = AXI_BURST_INCR;
        host_req_o = '0;
        host_req_o.aw = ax;
        host_req_o.ar = ax;
        host_req_o.w.data = wr_beat;
        host_req_o.w.strb = strb;
        host_req_o.w.last = 1'b1;
        host_req_o.aw_valid = aw_valid;
        host_req_o.w_valid = w_valid;
        host_req_o.ar_valid = ar_valid;
        host_req_o.b_ready = b_ready;
        host_req_o.r_ready = r_ready;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_id <= '0;
            host_addr <= '0;
            size <= '0;
            imm_data <= '0;
            resp_imm <= '0;
            resp_err <= 1'b0;
            aw_done <= 1'b0;
            w_done <= 1'b0;
        end else begin
            if (accept) begin
                cmd_id <= cmd_i.cmd_id;
                host_addr <= cmd_i.descr.host_direct_cmd.host_addr;
                size <= cmd_i.descr.host_direct_cmd.imm_data_size;
                imm_data <= cmd_i.descr.host_direct_cmd.imm_data;
                resp_imm <= '0;
                resp_err <= !legal;
                aw_done <= 1'b0;
                w_done <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) w_done <= 1'b1;
            if (b_hs) begin
                resp_err <= host_resp_i.b.resp != AXI_RESP_OKAY;
                resp_imm <= '0;
            end
            if (r_hs) begin
                resp_err <= r_err;
                resp_imm <= r_err ? '0 : rd_bytes;
            end
        end
    end
endmodule
